// File: rtl/video_monitor_pkg.sv
// Shared types, widths and CRC defaults for the TV-1 stream monitor.
// No logic; no backpressure.
package video_monitor_pkg;

    typedef enum logic {
        WAIT_VS = 1'b0,
        RUN     = 1'b1
    } state_t;

    localparam int W_PIX = 10;
    localparam int W_LEN = 11;
    localparam int W_CRC = 16;

    localparam logic [W_CRC-1:0] CRC_INIT_DEF = 16'hFFFF;
    localparam logic [W_CRC-1:0] CRC_POLY_DEF = 16'h1021;

    function automatic logic [W_PIX-1:0] sat_inc_pix(input logic [W_PIX-1:0] v);
        return (v == '1) ? v : v + W_PIX'(1);
    endfunction

    function automatic logic [W_LEN-1:0] sat_inc_len(input logic [W_LEN-1:0] v);
        return (v == '1) ? v : v + W_LEN'(1);
    endfunction

endpackage

// File: rtl/video_monitor_crc24.sv
// Combinational CRC-16 update over one 24-bit pixel, MSB (R[7]) first.
// Zero latency; no backpressure.
module video_monitor_crc24
    import video_monitor_pkg::*;
#(
    parameter logic [W_CRC-1:0] POLY = CRC_POLY_DEF
) (
    input  logic [W_CRC-1:0] crc_in,
    input  logic [23:0]      data,
    output logic [W_CRC-1:0] crc_out
);

    logic [W_CRC-1:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            c = (c[W_CRC-1] ^ data[i]) ? ({c[W_CRC-2:0], 1'b0} ^ POLY)
                                       : {c[W_CRC-2:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/video_monitor.sv
// Per-frame geometry and CRC signature of a DE/HS/VS/RGB pixel stream.
// Results land one clk after the CE sample holding the VS rise; no backpressure.
module video_monitor
    import video_monitor_pkg::*;
#(
    parameter logic [W_CRC-1:0] CRC_INIT = CRC_INIT_DEF,
    parameter logic [W_CRC-1:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ce,
    input  logic             de,
    input  logic             hs,
    input  logic             vs,
    input  logic [23:0]      rgb,
    output logic             frame_valid,
    output logic [W_PIX-1:0] act_w,
    output logic [W_PIX-1:0] act_h,
    output logic [W_LEN-1:0] line_len,
    output logic [W_PIX-1:0] lines,
    output logic [W_CRC-1:0] frame_crc,
    output logic             err_w,
    output logic [15:0]      frame_cnt
);

    state_t           state;
    logic             de_q, hs_q, vs_q;
    logic [W_PIX-1:0] pix_cnt;
    logic [W_PIX-1:0] ref_w;
    logic [W_PIX-1:0] act_h_cnt;
    logic             err_acc;
    logic [W_LEN-1:0] len_cnt;
    logic [W_LEN-1:0] len_cap;
    logic [W_PIX-1:0] line_cnt;
    logic [W_CRC-1:0] crc_acc;

    logic             de_fall, hs_rise, vs_rise;
    logic             first_close, w_mismatch;
    logic [W_CRC-1:0] crc_seed, crc_next;

    assign de_fall = de_q & ~de;
    assign hs_rise = hs & ~hs_q;
    assign vs_rise = vs & ~vs_q;

    // The first line close of a frame defines the reference width.
    assign first_close = de_fall && (act_h_cnt == '0);
    assign w_mismatch  = de_fall && (act_h_cnt != '0) && (pix_cnt != ref_w);

    // A pixel on the VS-rise sample opens the new frame's CRC from the seed.
    assign crc_seed = vs_rise ? CRC_INIT : crc_acc;

    video_monitor_crc24 #(
        .POLY    (CRC_POLY)
    ) u_crc (
        .crc_in  (crc_seed),
        .data    (rgb),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        frame_valid <= 1'b0;
        if (res) begin
            state       <= WAIT_VS;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            pix_cnt     <= '0;
            ref_w       <= '0;
            act_h_cnt   <= '0;
            err_acc     <= 1'b0;
            len_cnt     <= '0;
            len_cap     <= '0;
            line_cnt    <= '0;
            crc_acc     <= CRC_INIT;
            act_w       <= '0;
            act_h       <= '0;
            line_len    <= '0;
            lines       <= '0;
            frame_crc   <= '0;
            err_w       <= 1'b0;
            frame_cnt   <= '0;
        end else if (ce) begin
            de_q <= de;
            hs_q <= hs;
            vs_q <= vs;
            if (vs_rise) begin
                // Old frame absorbs a closing line; HS rise and pixel go to the new one.
                if (state == RUN) begin
                    frame_valid <= 1'b1;
                    act_w       <= first_close ? pix_cnt : ref_w;
                    act_h       <= de_fall ? sat_inc_pix(act_h_cnt) : act_h_cnt;
                    err_w       <= err_acc | w_mismatch;
                    line_len    <= len_cap;
                    lines       <= line_cnt;
                    frame_crc   <= crc_acc;
                    frame_cnt   <= frame_cnt + 16'd1;
                end
                state     <= RUN;
                pix_cnt   <= de ? W_PIX'(1) : '0;
                ref_w     <= '0;
                act_h_cnt <= '0;
                err_acc   <= 1'b0;
                len_cnt   <= W_LEN'(1);
                len_cap   <= '0;
                line_cnt  <= hs_rise ? W_PIX'(1) : '0;
                crc_acc   <= de ? crc_next : CRC_INIT;
            end else if (state == RUN) begin
                if (de_fall) begin
                    act_h_cnt <= sat_inc_pix(act_h_cnt);
                    if (first_close) begin
                        ref_w <= pix_cnt;
                    end
                    if (w_mismatch) begin
                        err_acc <= 1'b1;
                    end
                    pix_cnt <= '0;
                end else if (de) begin
                    pix_cnt <= sat_inc_pix(pix_cnt);
                end
                // A line length only exists once a frame has seen two HS rises.
                if (hs_rise) begin
                    if (line_cnt != '0) begin
                        len_cap <= len_cnt;
                    end
                    len_cnt  <= W_LEN'(1);
                    line_cnt <= sat_inc_pix(line_cnt);
                end else begin
                    len_cnt <= sat_inc_len(len_cnt);
                end
                if (de) begin
                    crc_acc <= crc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_monitor.sv
// Bench for video_monitor: stream scenarios checked against a frame-level model.
module tb_video_monitor;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } smp_t;

    typedef struct packed {
        logic [9:0]  act_w;
        logic [9:0]  act_h;
        logic [10:0] line_len;
        logic [9:0]  lines;
        logic [15:0] crc;
        logic        err;
        logic [15:0] cnt;
    } rep_t;

    logic        clk = 1'b0;
    logic        res, ce, de, hs, vs;
    logic [23:0] rgb;
    logic        frame_valid;
    logic [9:0]  act_w, act_h, lines;
    logic [10:0] line_len;
    logic [15:0] frame_crc, frame_cnt;
    logic        err_w;

    int   vectors = 0;
    int   miscompares = 0;
    smp_t log_q[$];
    rep_t got_q[$];
    rep_t exp_q[$];
    logic vs_hist, rise_q;

    always #5 clk = ~clk;

    video_monitor dut (
        .clk         (clk),
        .res         (res),
        .ce          (ce),
        .de          (de),
        .hs          (hs),
        .vs          (vs),
        .rgb         (rgb),
        .frame_valid (frame_valid),
        .act_w       (act_w),
        .act_h       (act_h),
        .line_len    (line_len),
        .lines       (lines),
        .frame_crc   (frame_crc),
        .err_w       (err_w),
        .frame_cnt   (frame_cnt)
    );

    // Remembers whether the previous edge sampled a VS rise on CE.
    always @(posedge clk) begin
        if (res) begin
            vs_hist <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= ce && vs && !vs_hist;
            if (ce) vs_hist <= vs;
        end
    end

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            vectors++;
            if (rise_q !== 1'b1) begin
                miscompares++;
                $display("FAIL fv_latency: frame_valid high, previous edge VS-rise sample=%b, required 1", rise_q);
            end
            got_q.push_back({act_w, act_h, line_len, lines, frame_crc, err_w, frame_cnt});
        end
    end

    function automatic string fmt(input rep_t r);
        return $sformatf("w=%0d h=%0d len=%0d lines=%0d crc=%h err=%0d cnt=%0d",
                         r.act_w, r.act_h, r.line_len, r.lines, r.crc, r.err, r.cnt);
    endfunction

    // Byte-wise CRC-16-CCITT, R then G then B.
    function automatic logic [15:0] crc_bytes(input logic [15:0] seed, input logic [23:0] px);
        logic [15:0] c;
        c = seed;
        for (int b = 2; b >= 0; b--) begin
            c ^= {px[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Splits the logged sample stream at VS rises and derives each frame's report.
    task automatic build_expected();
        int   starts[$];
        int   widths[$];
        int   hsr[$];
        int   k0, k1, w;
        rep_t r;
        exp_q.delete();
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].vs && (i == 0 || !log_q[i-1].vs)) starts.push_back(i);
        for (int f = 0; f + 1 < starts.size(); f++) begin
            k0 = starts[f];
            k1 = starts[f+1];
            widths.delete();
            hsr.delete();
            r = '0;
            r.crc = 16'hFFFF;
            for (int k = k0; k < k1; k++) begin
                if (log_q[k].hs && (k == 0 || !log_q[k-1].hs)) hsr.push_back(k);
                if (log_q[k].de) r.crc = crc_bytes(r.crc, log_q[k].rgb);
            end
            for (int k = k0 + 1; k <= k1; k++) begin
                if (log_q[k-1].de && !log_q[k].de) begin
                    w = 0;
                    for (int j = k - 1; j >= k0 && log_q[j].de; j--) w++;
                    widths.push_back(w > 1023 ? 1023 : w);
                end
            end
            r.act_h = 10'(widths.size() > 1023 ? 1023 : widths.size());
            r.act_w = widths.size() > 0 ? 10'(widths[0]) : 10'd0;
            for (int i = 1; i < widths.size(); i++) if (widths[i] != widths[0]) r.err = 1'b1;
            r.lines = 10'(hsr.size() > 1023 ? 1023 : hsr.size());
            if (hsr.size() >= 2) begin
                w = hsr[hsr.size()-1] - hsr[hsr.size()-2];
                r.line_len = 11'(w > 2047 ? 2047 : w);
            end
            r.cnt = 16'(f + 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic send(input logic d, input logic h, input logic v, input logic [23:0] p, input int gap);
        ce = 1'b1; de = d; hs = h; vs = v; rgb = p;
        log_q.push_back({d, h, v, p});
        @(negedge clk);
        repeat (gap) begin
            ce = 1'b0; de = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom); rgb = 24'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 1'b0, 1'b0, 24'h0, 0);
    endtask

    // VS high through line 0, HS high on the first two samples of each line.
    task automatic send_frame(input int n_lines, input int llen, input int act0, input int n_act,
                              input int de_start, input int de_w, input int bad_line, input int bad_w,
                              input int gap, input bit fixed_rgb, input int flip_line);
        for (int l = 0; l < n_lines; l++) begin
            for (int s = 0; s < llen; s++) begin
                int          w, g;
                logic        d;
                logic [23:0] p;
                w = (l == bad_line) ? bad_w : de_w;
                d = (l >= act0) && (l < act0 + n_act) && (s >= de_start) && (s < de_start + w);
                p = fixed_rgb ? {8'(l), 8'(s), 8'hA5} : 24'($urandom);
                if (l == flip_line && s == de_start) p[0] = ~p[0];
                g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                send(d, s < 2, l == 0, p, g);
            end
        end
    endtask

    task automatic do_reset();
        ce = 1'b0; res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        log_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        res = 1'b1; ce = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = 24'h0;
        repeat (2) @(negedge clk);
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b need 0", frame_valid); end
        vectors++; if (act_w !== 10'd0) begin miscompares++; $display("FAIL reset_act_w: got %0d need 0", act_w); end
        vectors++; if (act_h !== 10'd0) begin miscompares++; $display("FAIL reset_act_h: got %0d need 0", act_h); end
        vectors++; if (line_len !== 11'd0) begin miscompares++; $display("FAIL reset_line_len: got %0d need 0", line_len); end
        vectors++; if (lines !== 10'd0) begin miscompares++; $display("FAIL reset_lines: got %0d need 0", lines); end
        vectors++; if (frame_crc !== 16'd0) begin miscompares++; $display("FAIL reset_crc: got %h need 0", frame_crc); end
        vectors++; if (err_w !== 1'b0) begin miscompares++; $display("FAIL reset_err_w: got %b need 0", err_w); end
        vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d need 0", frame_cnt); end
        res = 1'b0;
        log_q.delete();
        got_q.delete();
    endtask

    task automatic test_geometry();
        do_reset();
        idle(3);
        repeat (3) send_frame(6, 16, 1, 4, 3, 10, -1, 0, 6, 1'b0, -1);
        idle(2);
        vectors++;
        if (got_q.size() !== 2) begin miscompares++; $display("FAIL geom_pulses: got %0d need 2", got_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if ({got_q[i].act_w, got_q[i].act_h, got_q[i].line_len, got_q[i].lines, got_q[i].err} !==
                {10'd10, 10'd4, 11'd16, 10'd6, 1'b0}) begin
                miscompares++; $display("FAIL geom_report[%0d]: got %s need w=10 h=4 len=16 lines=6 err=0", i, fmt(got_q[i]));
            end
        end
        vectors++;
        if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL geom_frame_cnt: got %0d need 2", frame_cnt); end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL geom_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_width_err();
        do_reset();
        idle(3);
        for (int f = 0; f < 4; f++) send_frame(6, 16, 1, 4, 3, 10, (f == 1) ? 3 : -1, 9, 6, 1'b0, -1);
        idle(2);
        vectors++;
        if (got_q.size() !== 3) begin miscompares++; $display("FAIL werr_pulses: got %0d need 3", got_q.size()); end
        if (got_q.size() >= 3) begin
            vectors++;
            if ({got_q[1].err, got_q[1].act_w} !== {1'b1, 10'd10}) begin
                miscompares++; $display("FAIL werr_bad_frame: got %s need err=1 w=10", fmt(got_q[1]));
            end
            vectors++;
            if (got_q[2].err !== 1'b0) begin miscompares++; $display("FAIL werr_next_frame: got err=%b need 0", got_q[2].err); end
        end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL werr_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_crc();
        do_reset();
        idle(3);
        send_frame(5, 14, 1, 3, 2, 8, -1, 0, 0, 1'b1, -1);
        send_frame(5, 14, 1, 3, 2, 8, -1, 0, 0, 1'b1, -1);
        send_frame(5, 14, 1, 3, 2, 8, -1, 0, 0, 1'b1, 2);
        send_frame(3, 14, 1, 1, 2, 8, -1, 0, 0, 1'b0, -1);
        idle(2);
        vectors++;
        if (got_q.size() !== 3) begin miscompares++; $display("FAIL crc_pulses: got %0d need 3", got_q.size()); end
        if (got_q.size() >= 3) begin
            vectors++;
            if (got_q[1].crc !== got_q[0].crc) begin miscompares++; $display("FAIL crc_same: got %h need %h", got_q[1].crc, got_q[0].crc); end
            vectors++;
            if (got_q[2].crc === got_q[1].crc) begin miscompares++; $display("FAIL crc_flip: got %h need a value other than %h", got_q[2].crc, got_q[1].crc); end
        end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL crc_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_zero_pixel();
        logic [15:0] want;
        do_reset();
        idle(3);
        send(1'b1, 1'b0, 1'b1, 24'h0, 1);
        repeat (4) send(1'b0, 1'b0, 1'b1, 24'h0, 1);
        repeat (4) send(1'b0, 1'b0, 1'b0, 24'h0, 1);
        send(1'b0, 1'b0, 1'b1, 24'h123456, 1);
        idle(3);
        want = crc_bytes(16'hFFFF, 24'h0);
        vectors++;
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL zpix_pulses: got %0d need 1", got_q.size()); end
        else begin
            vectors++;
            if (got_q[0].crc !== want) begin miscompares++; $display("FAIL zpix_crc: got %h need %h", got_q[0].crc, want); end
            vectors++;
            if ({got_q[0].act_w, got_q[0].act_h} !== {10'd1, 10'd1}) begin
                miscompares++; $display("FAIL zpix_geom: got %s need w=1 h=1", fmt(got_q[0]));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        idle(3);
        repeat (2) send_frame(6, 16, 1, 4, 3, 10, -1, 0, 2, 1'b0, -1);
        send_frame(3, 16, 1, 2, 3, 10, -1, 0, 2, 1'b0, -1);
        res = 1'b1; ce = 1'b0;
        @(negedge clk);
        res = 1'b0;
        log_q.delete();
        got_q.delete();
        vectors++;
        if ({frame_valid, act_w, act_h, line_len, lines, frame_crc, err_w, frame_cnt} !== 75'd0) begin
            miscompares++;
            $display("FAIL mreset_outputs: got fv=%b w=%0d h=%0d len=%0d lines=%0d crc=%h err=%b cnt=%0d need all 0",
                     frame_valid, act_w, act_h, line_len, lines, frame_crc, err_w, frame_cnt);
        end
        idle(5);
        repeat (2) send_frame(6, 16, 1, 4, 3, 10, -1, 0, 2, 1'b0, -1);
        idle(2);
        vectors++;
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL mreset_pulses: got %0d need 1", got_q.size()); end
        else begin
            vectors++;
            if (got_q[0].cnt !== 16'd1) begin miscompares++; $display("FAIL mreset_cnt: got %0d need 1", got_q[0].cnt); end
        end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL mreset_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        idle(3);
        repeat (3) send_frame(6, 16, 0, 6, 6, 10, -1, 0, 2, 1'b0, -1);
        idle(2);
        vectors++;
        if (got_q.size() !== 2) begin miscompares++; $display("FAIL coin_pulses: got %0d need 2", got_q.size()); end
        foreach (got_q[i]) begin
            vectors++;
            if ({got_q[i].act_w, got_q[i].act_h, got_q[i].line_len, got_q[i].lines, got_q[i].err} !==
                {10'd10, 10'd6, 11'd16, 10'd6, 1'b0}) begin
                miscompares++; $display("FAIL coin_report[%0d]: got %s need w=10 h=6 len=16 lines=6 err=0", i, fmt(got_q[i]));
            end
        end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL coin_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        idle(3);
        for (int s = 0; s < 2110; s++)
            send((s >= 1) && (s <= 1100), (s == 0) || (s == 2100), s < 16, 24'($urandom), 0);
        send(1'b0, 1'b0, 1'b1, 24'h0, 0);
        idle(3);
        vectors++;
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL sat_pulses: got %0d need 1", got_q.size()); end
        else begin
            vectors++;
            if ({got_q[0].act_w, got_q[0].act_h, got_q[0].line_len, got_q[0].lines, got_q[0].err} !==
                {10'd1023, 10'd1, 11'd2047, 10'd2, 1'b0}) begin
                miscompares++; $display("FAIL sat_report: got %s need w=1023 h=1 len=2047 lines=2 err=0", fmt(got_q[0]));
            end
        end
        build_expected();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL sat_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        int nl, ll, a0, na, ds, dw, bl, bw;
        do_reset();
        idle(3);
        repeat (6) begin
            nl = $urandom_range(8, 3);
            ll = $urandom_range(24, 12);
            a0 = $urandom_range(1, 0);
            na = $urandom_range(nl - a0, 1);
            ds = $urandom_range(3, 0);
            dw = $urandom_range(ll - ds, 1);
            bl = $urandom_range(nl - 1, 0);
            bw = $urandom_range(ll - ds, 1);
            send_frame(nl, ll, a0, na, ds, dw, bl, bw, -1, 1'b0, -1);
        end
        send_frame(2, 12, 0, 1, 2, 5, -1, 0, -1, 1'b0, -1);
        idle(2);
        build_expected();
        vectors++;
        if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_pulses: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_model[%0d]: got %s need %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_width_err();
        test_crc();
        test_zero_pixel();
        test_mid_reset();
        test_coincident();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
